// File: rtl/lasx_bank_pkg.sv
// rtl/lasx_bank_pkg.sv - command encodings, FSM state codes and widths for the latch bank sequencer
package lasx_bank_pkg;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'd0,
    OP_PRESET = 2'd1,
    OP_HOLD   = 2'd2,
    OP_READ   = 2'd3
  } cmd_op_e;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_W_SETUP  = 4'd1;
  localparam state_t ST_W_OPEN   = 4'd2;
  localparam state_t ST_W_CLOSE  = 4'd3;
  localparam state_t ST_P_SET    = 4'd4;
  localparam state_t ST_P_RECOV  = 4'd5;
  localparam state_t ST_HOLD     = 4'd6;
  localparam state_t ST_R_SAMPLE = 4'd7;
  localparam state_t ST_R_RESP   = 4'd8;

  localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/lasx_bank_timer.sv
// rtl/lasx_bank_timer.sv - loadable down-counter with a zero/done flag
// Shared by the preset strobe and HOLD; holds at zero until reloaded.
module lasx_bank_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lasx_bank_seq.sv
// rtl/lasx_bank_seq.sv - command sequencer generating D/gate/set strobes for a bank of set-able latches
// Optional LASX_BANK_SEQ_CHECK_EN adds an expected-value register and saturating readback error counter.
module lasx_bank_seq
  import lasx_bank_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SET_CYC = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [WIDTH-1:0] cmd_data_i,
  input  logic [CNT_W-1:0] cmd_cnt_i,
  output logic [WIDTH-1:0] lat_d_o,
  output logic             lat_en_o,
  output logic             lat_setb_o,
  input  logic [WIDTH-1:0] lat_q_i,
  output logic             rsp_valid_o,
  output logic [WIDTH-1:0] rsp_data_o,
`ifdef LASX_BANK_SEQ_CHECK_EN
  output logic [ERR_CNT_W-1:0] err_cnt_o,
`endif
  output logic             busy_o
);

  localparam int TW = (CNT_W > $clog2(SET_CYC) + 1) ? CNT_W : $clog2(SET_CYC) + 1;

  state_t           state_q, state_d;
  logic             ready_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] lat_d_q;
  logic             lat_en_q;
  logic             lat_setb_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;

  logic             accept;
  logic             tmr_load;
  logic [TW-1:0]    tmr_val;
  logic             tmr_dec;
  logic             tmr_done;

  assign accept = cmd_valid_i & ready_q;

  lasx_bank_timer #(.W(TW)) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_op_i)
            OP_WRITE:  state_d = ST_W_SETUP;
            OP_PRESET: begin
              state_d  = ST_P_SET;
              tmr_load = 1'b1;
              tmr_val  = TW'(SET_CYC - 1);
            end
            OP_HOLD: begin
              // A zero count still occupies one HOLD cycle.
              state_d  = ST_HOLD;
              tmr_load = 1'b1;
              tmr_val  = (cmd_cnt_i == '0) ? '0 : TW'(cmd_cnt_i - 1'b1);
            end
            default:   state_d = ST_R_SAMPLE;
          endcase
        end
      end
      ST_W_SETUP:  state_d = ST_W_OPEN;
      ST_W_OPEN:   state_d = ST_W_CLOSE;
      ST_W_CLOSE:  state_d = ST_IDLE;
      ST_P_SET: begin
        if (tmr_done) state_d = ST_P_RECOV;
        else          tmr_dec = 1'b1;
      end
      ST_P_RECOV:  state_d = ST_IDLE;
      ST_HOLD: begin
        if (tmr_done) state_d = ST_IDLE;
        else          tmr_dec = 1'b1;
      end
      ST_R_SAMPLE: state_d = ST_R_RESP;
      ST_R_RESP:   state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Strobes are registered from the current state, so each lags its state by one edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      data_q      <= '0;
      lat_d_q     <= '0;
      lat_en_q    <= 1'b0;
      lat_setb_q  <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= (state_d == ST_IDLE);
      if (accept) data_q <= cmd_data_i;
      if (state_q == ST_W_SETUP) lat_d_q <= data_q;
      lat_en_q    <= (state_q == ST_W_OPEN);
      lat_setb_q  <= (state_q != ST_P_SET);
      rsp_valid_q <= (state_q == ST_R_RESP);
      if (state_q == ST_R_SAMPLE) rsp_data_q <= lat_q_i;
    end
  end

  assign cmd_ready_o = ready_q;
  assign busy_o      = ~ready_q;
  assign lat_d_o     = lat_d_q;
  assign lat_en_o    = lat_en_q;
  assign lat_setb_o  = lat_setb_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;

`ifdef LASX_BANK_SEQ_CHECK_EN
  logic [WIDTH-1:0]     exp_q;
  logic                 exp_vld_q;
  logic [ERR_CNT_W-1:0] err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exp_q     <= '0;
      exp_vld_q <= 1'b0;
      err_q     <= '0;
    end else begin
      if (accept && (cmd_op_i == OP_WRITE)) begin
        exp_q     <= cmd_data_i;
        exp_vld_q <= 1'b1;
      end else if (accept && (cmd_op_i == OP_PRESET)) begin
        exp_q     <= '1;
        exp_vld_q <= 1'b1;
      end
      if ((state_q == ST_R_SAMPLE) && exp_vld_q && (lat_q_i != exp_q) && (err_q != '1)) begin
        err_q <= err_q + 1'b1;
      end
    end
  end

  assign err_cnt_o = err_q;
`endif

endmodule

// File: tb/tb_lasx_bank_seq.sv
// tb/tb_lasx_bank_seq.sv - scoreboard bench for lasx_bank_seq with a behavioural latch bank
// Exercises the LASX_BANK_SEQ_CHECK_EN error counter when that macro is defined.
module tb_lasx_bank_seq;

  localparam int WIDTH   = 8;
  localparam int SET_CYC = 2;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_op = 2'd0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic [CNT_W-1:0] cmd_cnt = '0;
  logic             cmd_ready, lat_en, lat_setb, rsp_valid, busy;
  logic [WIDTH-1:0] lat_d, lat_q, rsp_data;
`ifdef LASX_BANK_SEQ_CHECK_EN
  logic [15:0]      err_cnt;
  int               err_exp = 0;
  bit               exp_vld = 1'b0;
  logic [WIDTH-1:0] exp_val = '0;
`endif

  logic [WIDTH-1:0] latch_q = '0;
  bit               force_on = 1'b0;
  logic [WIDTH-1:0] force_val = '0;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [WIDTH-1:0] d;
    bit               dc;
  } rsp_t;

  rsp_t             rsp_q[$];
  int               occ_q[$];
  logic [WIDTH-1:0] wr_q[$];
  logic [WIDTH-1:0] mem = '0;
  bit               mem_known = 1'b0;

  always #5 clk = ~clk;

  // Transparent-high latch with active-low asynchronous set.
  always @(lat_en or lat_setb or lat_d) begin
    if (!lat_setb)   latch_q = '1;
    else if (lat_en) latch_q = lat_d;
  end

  always_comb lat_q = force_on ? force_val : latch_q;

  lasx_bank_seq #(.WIDTH(WIDTH), .SET_CYC(SET_CYC), .CNT_W(CNT_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_data_i  (cmd_data),
    .cmd_cnt_i   (cmd_cnt),
    .lat_d_o     (lat_d),
    .lat_en_o    (lat_en),
    .lat_setb_o  (lat_setb),
    .lat_q_i     (lat_q),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
`ifdef LASX_BANK_SEQ_CHECK_EN
    .err_cnt_o   (err_cnt),
`endif
    .busy_o      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] c);
    int n = 0;
    logic [WIDTH-1:0] seen;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_cnt   = c;
    case (op)
      2'd0: begin
        mem = d; mem_known = 1'b1;
        occ_q.push_back(3);
        wr_q.push_back(d);
`ifdef LASX_BANK_SEQ_CHECK_EN
        exp_vld = 1'b1; exp_val = d;
`endif
      end
      2'd1: begin
        mem = '1; mem_known = 1'b1;
        occ_q.push_back(SET_CYC + 1);
`ifdef LASX_BANK_SEQ_CHECK_EN
        exp_vld = 1'b1; exp_val = '1;
`endif
      end
      2'd2: occ_q.push_back((c == 0) ? 1 : int'(c));
      default: begin
        seen = force_on ? force_val : mem;
        occ_q.push_back(2);
        rsp_q.push_back('{d: seen, dc: !(mem_known || force_on)});
`ifdef LASX_BANK_SEQ_CHECK_EN
        if (exp_vld && seen != exp_val) err_exp++;
`endif
      end
    endcase
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", cmd_ready, 1);
  endtask

  int               occ_run = 0;
  int               en_run = 0;
  int               setb_run = 0;
  logic [WIDTH-1:0] prev_d = '0;
  logic [WIDTH-1:0] en_d = '0;
  rsp_t             mon_e;

  always @(negedge clk) begin
    if (!mon_en || rst) begin
      occ_run = 0; en_run = 0; setb_run = 0;
    end else begin
      if (rsp_valid) begin
        if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          mon_e = rsp_q.pop_front();
          if (!mon_e.dc) chk("rsp_data", rsp_data, mon_e.d);
        end
      end
      if (!cmd_ready) occ_run++;
      else if (occ_run > 0) begin
        if (occ_q.size() == 0) chk("occ_unexpected", occ_run, 0);
        else chk("occupancy", occ_run, occ_q.pop_front());
        occ_run = 0;
      end
      if (lat_en) begin
        chk("en_setb_excl", lat_setb, 1);
        if (en_run == 0) begin
          chk("d_setup", lat_d, prev_d);
          if (wr_q.size() == 0) chk("write_unexpected", 1, 0);
          else chk("write_data", lat_d, wr_q.pop_front());
          en_d = lat_d;
        end
        en_run++;
      end else if (en_run > 0) begin
        chk("en_width", en_run, 1);
        chk("d_hold", lat_d, en_d);
        en_run = 0;
      end
      if (!lat_setb) setb_run++;
      else if (setb_run > 0) begin
        chk("setb_width", setb_run, SET_CYC);
        setb_run = 0;
      end
    end
    prev_d = lat_d;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_lat_d", lat_d, 0);
    chk("rst_lat_en", lat_en, 0);
    chk("rst_setb", lat_setb, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_busy", busy, 0);
    mon_en = 1'b1;

    issue(2'd3, 8'h00, 8'd0);
    wait_idle();
`ifdef LASX_BANK_SEQ_CHECK_EN
    chk("err_read_before_write", err_cnt, 0);
`endif

    issue(2'd0, 8'hA5, 8'd0);
    @(negedge clk);
    chk("wr_k_en", lat_en, 0);
    @(negedge clk);
    chk("wr_k1_d", lat_d, 8'hA5);
    chk("wr_k1_en", lat_en, 0);
    @(negedge clk);
    chk("wr_k2_en", lat_en, 1);
    @(negedge clk);
    chk("wr_k3_en", lat_en, 0);
    chk("wr_k3_ready", cmd_ready, 1);
    issue(2'd3, 8'h00, 8'd0);

    issue(2'd1, 8'h00, 8'd0);
    @(negedge clk);
    chk("pre_k_setb", lat_setb, 1);
    for (int i = 1; i <= SET_CYC; i++) begin
      @(negedge clk);
      chk("pre_setb_low", lat_setb, 0);
      chk("pre_en_low", lat_en, 0);
    end
    @(negedge clk);
    chk("pre_release", lat_setb, 1);
    chk("pre_ready", cmd_ready, 1);
    issue(2'd3, 8'h00, 8'd0);

    issue(2'd2, 8'h00, 8'd0);
    issue(2'd2, 8'h00, 8'd5);
    wait_idle();

`ifdef LASX_BANK_SEQ_CHECK_EN
    issue(2'd0, 8'h3C, 8'd0);
    wait_idle();
    force_val = 8'h3D;
    force_on  = 1'b1;
    issue(2'd3, 8'h00, 8'd0);
    wait_idle();
    force_on = 1'b0;
    chk("err_forced_mismatch", err_cnt, err_exp);
`endif

    for (int i = 0; i < 60; i++) begin
      issue(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom_range(0, 6)));
    end
    wait_idle();
`ifdef LASX_BANK_SEQ_CHECK_EN
    chk("err_after_random", err_cnt, err_exp);
`endif

    issue(2'd1, 8'h00, 8'd0);
    mon_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_setb_low", lat_setb, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_setb", lat_setb, 1);
    chk("mid_rst_en", lat_en, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    rst = 1'b0;
    occ_q.delete();
    rsp_q.delete();
    wr_q.delete();
`ifdef LASX_BANK_SEQ_CHECK_EN
    exp_vld = 1'b0;
    err_exp = 0;
`endif
    @(negedge clk);
    chk("mid_idle_ready", cmd_ready, 1);
    chk("mid_idle_rsp_valid", rsp_valid, 0);
`ifdef LASX_BANK_SEQ_CHECK_EN
    chk("mid_err_reset", err_cnt, 0);
`endif
    mon_en = 1'b1;

    issue(2'd3, 8'h00, 8'd0);
    wait_idle();
    repeat (4) @(negedge clk);
    chk("rsp_q_drained", rsp_q.size(), 0);
    chk("occ_q_drained", occ_q.size(), 0);
    chk("wr_q_drained", wr_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
